mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one external memory port between two requesters: the CPU control/datapath (port 0) and the debug/UART program loader (port 1).
- Every port, upstream and downstream, uses the same active-low ce / busy / valid handshake as the core's memory interface.
- Adds round-robin arbitration, routes the handshake back to the granted requester only, and raises a single-cycle access fault when the memory never starts a request.

Parameters:
ADDR_W, 24, address width on all ports
DATA_W, 32, data width on all ports
TIMEOUT, 64, cycles to wait for downstream busy before a fault; must be >= 2
CNT_W, 7, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ce0_n  in  1  CPU request, active low, held until its busy falls
we0  in  1  CPU write enable
addr0  in  ADDR_W  CPU address
wdata0  in  DATA_W  CPU write data
busy0  out  1  downstream busy, routed to CPU while granted, else 0
valid0  out  1  downstream valid, routed to CPU while granted, else 0
fault0  out  1  one-cycle timeout fault to CPU
ce1_n, we1, addr1, wdata1, busy1, valid1, fault1: same as port 0, for the loader
rdata  out  DATA_W  downstream read data, fanned out to both ports
mem_ce_n  out  1  downstream request, active low
mem_we  out  1  downstream write enable
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_busy  in  1  downstream busy
mem_valid  in  1  downstream read data valid
mem_rdata  in  DATA_W  downstream read data
grant  out  1  current or last owner (0 = CPU, 1 = loader)

Behaviour:
- Reset values, entered on the clock edge with reset=0, from any state including mid-transaction:
  - state=IDLE, mem_ce_n=1, all busy/valid/fault outputs 0.
  - grant=1, so the CPU wins the first tie.
  - Timeout counter 0.
- States: IDLE, AWAIT, ACTIVE, RELEASE.
- IDLE:
  - mem_ce_n=1.
  - Request pending on ceX_n=0. If both are pending, grant goes to the port not granted last (round robin). If one is pending, that port wins.
  - On a grant: latch grant, clear the counter, go to AWAIT. Arbitration costs 1 cycle.
- AWAIT:
  - mem_ce_n=0; mem_we/addr/wdata driven combinationally from the granted port.
  - mem_busy=1 -> ACTIVE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 and mem_busy is still 0: pulse faultX for the granted port for 1 cycle, then go to RELEASE.
  - If the granted port deasserts ceX_n before mem_busy rises, the request is abandoned: go to RELEASE with no fault.
- ACTIVE:
  - mem_ce_n=0; downstream signals keep following the granted port.
  - mem_busy=0 -> RELEASE.
  - No timeout in ACTIVE.
- RELEASE:
  - mem_ce_n=1 for exactly 1 cycle, guaranteeing a ce edge between transactions. Then go to IDLE.
- Routing:
  - busyX = mem_busy and validX = mem_valid, only when X is granted and state is AWAIT or ACTIVE. The non-granted port sees 0 on both, so its requester stays in its await state.
  - rdata = mem_rdata, unconditionally.
- The fault pulse and a concurrent mem_busy rise in the same cycle: busy wins and no fault is issued.
- mem_valid outside AWAIT/ACTIVE is ignored.
- Back-to-back requests from one port with the other idle: that port is granted again. Minimum turnaround is RELEASE + IDLE = 2 cycles of mem_ce_n=1 between transactions.
- A request arriving at one port during the other's transaction waits; it is served at the next IDLE.
- grant changes only on the IDLE->AWAIT transition.

Test Plan:
- Reset mid-ACTIVE (state=ACTIVE, mem_busy=1, reset=0 one cycle) -> next cycle mem_ce_n=1, busy0=busy1=0, grant=1; state IDLE.
- CPU-only read, addr0=0x000100, memory model raises busy 2 cycles after ce, holds it 3 cycles, valid with rdata=0xDEADBEEF -> mem_addr=0x000100, valid0=1 with rdata=0xDEADBEEF; busy1/valid1 stay 0; mem_ce_n high 1 cycle after busy falls.
- Both ce0_n and ce1_n low from reset release -> CPU granted first (grant=0), then loader (grant=1). Loader's busy1 stays 0 throughout CPU's transaction.
- Loader write, we1=1, addr1=0x000040, wdata1=0x12345678, while CPU idle -> mem_we=1, mem_wdata=0x12345678; busy1 mirrors mem_busy; busy0=0.
- Memory never raises busy, CPU request, TIMEOUT=64 -> fault0 high exactly 1 cycle, 64 cycles after entering AWAIT; then RELEASE and IDLE. A continued request is re-granted.
- CPU drops ce0_n in AWAIT before busy -> no fault, RELEASE, pending loader request granted next.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one active-low ce/busy/valid memory port
// between the CPU (port 0) and the debug loader (port 1), with an access-start timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce0_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              busy0,
    output logic              valid0,
    output logic              fault0,
    input  logic              ce1_n,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              busy1,
    output logic              valid1,
    output logic              fault1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ce_n,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant
);
    typedef enum logic [1:0] {IDLE, AWAIT, ACTIVE, RELEASE} state_t;
    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fault_q, fault_d;
    logic             gnt_ce_n;
    logic             routed;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
    assign gnt_ce_n = grant_q ? ce1_n : ce0_n;
    // busy is checked before abandon/timeout so a late busy always wins over a fault
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        fault_d = '0;
        case (state_q)
            IDLE: begin
                if (!ce0_n || !ce1_n) begin
                    grant_d = (!ce0_n && !ce1_n) ? ~grant_q : !ce1_n;
                    cnt_d   = '0;
                    state_d = AWAIT;
                end
            end
            AWAIT: begin
                if (mem_busy) begin
                    state_d = ACTIVE;
                end else if (gnt_ce_n) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fault_d[grant_q] = 1'b1;
                    state_d          = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: state_d = mem_busy ? ACTIVE : RELEASE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        routed    = (state_q == AWAIT) || (state_q == ACTIVE);
        mem_ce_n  = !routed;
        mem_we    = grant_q ? we1 : we0;
        mem_addr  = grant_q ? addr1 : addr0;
        mem_wdata = grant_q ? wdata1 : wdata0;
        busy0     = routed && !grant_q && mem_busy;
        valid0    = routed && !grant_q && mem_valid;
        busy1     = routed && grant_q && mem_busy;
        valid1    = routed && grant_q && mem_valid;
        fault0    = fault_q[0];
        fault1    = fault_q[1];
        rdata     = mem_rdata;
        grant     = grant_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and a randomized run
// against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce0_n = 1'b1, we0 = 1'b0, ce1_n = 1'b1, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          busy0, valid0, fault0, busy1, valid1, fault1;
    logic [DW-1:0] rdata;
    logic          mem_ce_n, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_busy = 1'b0, mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          grant;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .ce0_n(ce0_n), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .busy0(busy0), .valid0(valid0), .fault0(fault0),
        .ce1_n(ce1_n), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .busy1(busy1), .valid1(valid1), .fault1(fault1),
        .rdata(rdata), .mem_ce_n(mem_ce_n), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    logic [7:0] outs;
    assign outs = {mem_ce_n, busy0, valid0, fault0, busy1, valid1, fault1, grant};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic       ce0_n;
        logic       ce1_n;
        logic       mb;
        logic       mv;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[11];

    // Reference model: one outstanding transaction, its owner, whether memory has
    // started it, how long it has waited, and the forced ce-high gap afterwards.
    bit       m_live, m_started, m_owner;
    int       m_waited, m_cool;
    bit [1:0] m_fault;

    task automatic model_reset();
        m_live = 0; m_started = 0; m_owner = 1; m_waited = 0; m_cool = 0; m_fault = '0;
    endtask

    task automatic model_step();
        bit [1:0] nf;
        bit       r0, r1;
        nf = '0;
        r0 = !ce0_n;
        r1 = !ce1_n;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_live) begin
            if (m_started) begin
                if (!mem_busy) begin m_live = 0; m_cool = 1; end
            end else if (mem_busy) begin
                m_started = 1;
            end else if (!(m_owner ? r1 : r0)) begin
                m_live = 0; m_cool = 1;
            end else if (m_waited + 1 == TO) begin
                nf[m_owner] = 1; m_live = 0; m_cool = 1;
            end else begin
                m_waited++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r0 || r1) begin
            m_owner = (r0 && r1) ? !m_owner : r1;
            m_live = 1; m_started = 0; m_waited = 0;
        end
        m_fault = nf;
    endtask

    task automatic do_reset();
        reset = 1'b0; ce0_n = 1'b1; ce1_n = 1'b1; mem_busy = 1'b0; mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int t0, tf, tre, nf;
        logic [7:0] e;
        tbl[0]  = {4'b0000, 8'b1000_0001};
        tbl[1]  = {4'b0000, 8'b0000_0000};
        tbl[2]  = {4'b0010, 8'b0100_0000};
        tbl[3]  = {4'b0011, 8'b0110_0000};
        tbl[4]  = {4'b0000, 8'b0000_0000};
        tbl[5]  = {4'b1001, 8'b1000_0000};
        tbl[6]  = {4'b1000, 8'b1000_0000};
        tbl[7]  = {4'b1011, 8'b0000_1101};
        tbl[8]  = {4'b1000, 8'b0000_0001};
        tbl[9]  = {4'b1100, 8'b1000_0001};
        tbl[10] = {4'b1100, 8'b1000_0001};

        // both requesting from reset release: CPU first, then loader
        do_reset();
        addr0 = 24'h000100; addr1 = 24'h000200; mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 11; i++) begin
            ce0_n = tbl[i].ce0_n; ce1_n = tbl[i].ce1_n;
            mem_busy = tbl[i].mb; mem_valid = tbl[i].mv;
            #1;
            chk($sformatf("table_row%0d", i), outs, tbl[i].exp);
            if (i == 3) begin
                chk("cpu_read_addr", mem_addr, 24'h000100);
                chk("cpu_read_rdata", rdata, 32'hDEADBEEF);
            end
            @(negedge clk);
        end

        // reset while ACTIVE with memory still busy
        ce0_n = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        mem_busy = 1'b1;
        @(negedge clk);
        #1 chk("active_before_reset", outs, 8'b0100_0000);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; ce0_n = 1'b1;
        #1 chk("after_reset_mid_active", outs, 8'b1000_0001);
        mem_busy = 1'b0;
        @(negedge clk);

        // loader write while CPU idle
        ce1_n = 1'b0; we1 = 1'b1; addr1 = 24'h000040; wdata1 = 32'h12345678;
        we0 = 1'b0; addr0 = 24'h000999; wdata0 = 32'h0;
        @(negedge clk);
        mem_busy = 1'b1;
        #1;
        chk("ldr_write_down", {mem_ce_n, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 24'h000040, 32'h12345678});
        chk("ldr_write_busy_hi", {busy1, busy0}, 2'b10);
        @(negedge clk);
        mem_busy = 1'b0;
        #1 chk("ldr_write_busy_lo", {busy1, busy0, mem_ce_n}, 3'b000);
        @(negedge clk);
        ce1_n = 1'b1; we1 = 1'b0;
        @(negedge clk);

        // memory never answers: fault exactly 64 cycles after entering AWAIT
        ce0_n = 1'b0;
        t0 = -1; tf = -1; tre = -1; nf = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (t0 < 0 && !mem_ce_n) t0 = c;
            else if (tf >= 0 && tre < 0 && !mem_ce_n) tre = c;
            if (fault0) begin
                nf++;
                if (tf < 0) begin
                    tf = c;
                    chk("fault_in_release", mem_ce_n, 1'b1);
                end
            end
            if (fault1) nf += 100;
            @(negedge clk);
            if (tre >= 0) break;
        end
        chk("timeout_latency", tf - t0, TO);
        chk("fault_pulse_count", nf, 1);
        chk("regrant_gap", tre - tf, 2);

        // CPU abandons in AWAIT; waiting loader gets the port, no fault
        ce0_n = 1'b1; ce1_n = 1'b0;
        #1 chk("abandon_await", outs, 8'b0000_0000);
        @(negedge clk);
        #1 chk("abandon_release", outs, 8'b1000_0000);
        @(negedge clk);
        #1 chk("abandon_idle", outs, 8'b1000_0000);
        @(negedge clk);
        #1 chk("abandon_ldr_granted", outs, 8'b0000_0001);
        ce1_n = 1'b1;
        repeat (2) @(negedge clk);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            ce0_n = ce0_n ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            ce1_n = ce1_n ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = $urandom; wdata1 = $urandom;
            mem_busy = ($urandom_range(0, 9) < 4);
            mem_valid = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            e = {!m_live, m_live && !m_owner && mem_busy, m_live && !m_owner && mem_valid, m_fault[0],
                 m_live && m_owner && mem_busy, m_live && m_owner && mem_valid, m_fault[1], m_owner};
            chk("rand_outs", outs, e);
            chk("rand_rdata", rdata, mem_rdata);
            if (m_live)
                chk("rand_down", {mem_we, mem_addr, mem_wdata},
                    m_owner ? {we1, addr1, wdata1} : {we0, addr0, wdata0});
            model_step();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
